// File: rtl/instr_fetch_issue_if.sv
// Bus bundle for the fetch/issue front end: instruction-memory req/ack fetch port
// and the valid/ready issue port toward the decoder.
interface instr_fetch_issue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 10
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               issue_valid;
  logic               issue_ready;
  logic [1:0]         issue_op;
  logic [INSTR_W-3:0] issue_operand;
  logic [ADDR_W-1:0]  issue_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output issue_valid, issue_op, issue_operand, issue_pc,
    input  issue_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  issue_valid, issue_op, issue_operand, issue_pc,
    output issue_ready
  );
endinterface

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: PC walker, req/ack fetch FSM, prefetch FIFO,
// JUMP resolution at issue. Define ISSUE_CNT_EN to add the 16-bit issue_count_o.
module instr_fetch_issue #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt_i,
  instr_fetch_issue_if.master  bus
`ifdef ISSUE_CNT_EN
  ,
  output logic [15:0]          issue_count_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               drop_q;

  logic [INSTR_W-1:0] instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  epc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [INSTR_W-1:0] head_instr;
  logic [INSTR_W-3:0] head_operand;
  logic [ADDR_W+INSTR_W-3:0] target_wide;
  logic [ADDR_W-1:0]  jump_target;
  logic               issue_valid, pop, jump_hs, push, launch;

  assign head_instr   = instr_q[rd_ptr_q];
  assign head_operand = head_instr[INSTR_W-3:0];
  assign issue_valid  = (count_q != '0);
  assign pop          = issue_valid && bus.issue_ready;
  assign jump_hs      = pop && (head_instr[INSTR_W-1 -: 2] == 2'b11);
  assign target_wide  = {{ADDR_W{1'b0}}, head_operand};
  assign jump_target  = target_wide[ADDR_W-1:0];

  // A word returning for a request that a JUMP overtook is never pushed.
  assign push   = (state_q == REQ) && bus.imem_ack && !drop_q && !jump_hs;
  assign launch = (state_q == IDLE) && !halt_i && !jump_hs && (count_q < DEPTH_C);

  always_comb begin
    pc_d = pc_q;
    if (jump_hs)
      pc_d = jump_target;
    else if (push)
      pc_d = pc_q + ADDR_W'(1);
  end

  always_comb begin
    count_d = count_q;
    if (jump_hs)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
          end else if (jump_hs) begin
            drop_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (jump_hs) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          instr_q[wr_ptr_q] <= bus.imem_data;
          epc_q[wr_ptr_q]   <= addr_q;
          wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef ISSUE_CNT_EN
  logic [15:0] issue_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      issue_cnt_q <= '0;
    else if (pop)
      issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign issue_count_o = issue_cnt_q;
`endif

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = addr_q;
  assign bus.issue_valid   = issue_valid;
  assign bus.issue_op      = head_instr[INSTR_W-1 -: 2];
  assign bus.issue_operand = head_operand;
  assign bus.issue_pc      = epc_q[rd_ptr_q];

endmodule
